// File: rtl/dispatcher_pkg.sv
// rtl/dispatcher_pkg.sv - shared constants, types and helpers for the chunk sequencer
package dispatcher_pkg;

  localparam int MASK_W        = 1024;
  localparam int CHUNK_W       = 256;
  localparam int NUM_CHUNKS    = MASK_W / CHUNK_W;
  localparam int CHUNK_SHIFT   = 8;
  localparam int SETTLE_CYCLES = 2;

  typedef logic [1:0] chunk_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_SCAN,
    ST_FIN
  } seq_state_t;

  localparam logic [1:0] UF_1 = 2'd0;
  localparam logic [1:0] UF_2 = 2'd1;
  localparam logic [1:0] UF_4 = 2'd2;

  // The reserved encoding 3 is folded onto the widest legal factor.
  function automatic logic [1:0] norm_uf(input logic [1:0] uf);
    logic [1:0] r;
    case (uf)
      UF_1:    r = UF_1;
      UF_2:    r = UF_2;
      default: r = UF_4;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/chunk_nonzero_finder.sv
// rtl/chunk_nonzero_finder.sv - picks the lowest populated chunk within the active window
module chunk_nonzero_finder
  import dispatcher_pkg::*;
(
  input  logic [NUM_CHUNKS-1:0] chunk_nz,
  input  chunk_idx_t            cur_idx,
  input  logic                  first,
  input  chunk_idx_t            last_chunk,
  output chunk_idx_t            next_idx,
  output logic                  found
);

  // Walk downward so the lowest qualifying index is the one left standing.
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
      if (chunk_nz[i] && (chunk_idx_t'(i) <= last_chunk) &&
          (first || (chunk_idx_t'(i) > cur_idx))) begin
        found    = 1'b1;
        next_idx = chunk_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/thread_chunk_sequencer.sv
// rtl/thread_chunk_sequencer.sv - walks a block's active mask through the lanes one chunk at a time
module thread_chunk_sequencer
  import dispatcher_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [1023:0] active_mask,
  input  logic [10:0]  num_threads,
  input  logic [1:0]   unrolling_factor_in,
  input  logic         chunk_done,
  output logic         busy,
  output logic         done,
  output logic         restart,
  output logic [255:0] chunk_active_mask,
  output logic [1:0]   chunk_base_addr,
  output logic [1:0]   unrolling_factor,
  output logic [2:0]   chunks_issued
);

  seq_state_t         state_q, state_d;
  logic [MASK_W-1:0]  mask_q, mask_d;
  chunk_idx_t         last_q, last_d;
  chunk_idx_t         base_q, base_d;
  logic [CHUNK_W-1:0] cmask_q, cmask_d;
  logic [1:0]         uf_q, uf_d;
  logic [2:0]         issued_q, issued_d;
  logic [1:0]         settle_q, settle_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               restart_q, restart_d;

  logic [10:0]           nt_clamped;
  logic [MASK_W-1:0]     masked_in;
  chunk_idx_t            last_in;
  logic                  in_idle;
  logic [MASK_W-1:0]     scan_src;
  chunk_idx_t            scan_last;
  logic [NUM_CHUNKS-1:0] chunk_nz;
  chunk_idx_t            next_idx;
  logic                  found;
  logic [CHUNK_W-1:0]    next_cmask;

  // Strip threads beyond the block size and derive the last chunk that can hold work.
  always_comb begin
    nt_clamped = (num_threads > 11'd1024) ? 11'd1024 : num_threads;
    masked_in  = active_mask & ~({MASK_W{1'b1}} << nt_clamped);
    last_in    = chunk_idx_t'((nt_clamped - 11'd1) >> CHUNK_SHIFT);
  end

  // In IDLE the search looks at the incoming block; afterwards at the latched copy.
  always_comb begin
    in_idle   = (state_q == ST_IDLE);
    scan_src  = in_idle ? masked_in : mask_q;
    scan_last = in_idle ? last_in : last_q;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      chunk_nz[c] = |scan_src[c*CHUNK_W +: CHUNK_W];
    end
  end

  chunk_nonzero_finder u_finder (
    .chunk_nz   (chunk_nz),
    .cur_idx    (base_q),
    .first      (in_idle),
    .last_chunk (scan_last),
    .next_idx   (next_idx),
    .found      (found)
  );

  // Slice of the selected chunk, ready to be registered when a chunk is issued.
  always_comb begin
    next_cmask = scan_src[{next_idx, {CHUNK_SHIFT{1'b0}}} +: CHUNK_W];
  end

  // Sequencer next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    last_d    = last_q;
    base_d    = base_q;
    cmask_d   = cmask_q;
    uf_d      = uf_q;
    issued_d  = issued_q;
    settle_d  = settle_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    restart_d = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      // Cancel: pulse restart to flush the lanes, keep the issue count for inspection.
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      restart_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_d   = masked_in;
            last_d   = last_in;
            uf_d     = norm_uf(unrolling_factor_in);
            issued_d = 3'd0;
            busy_d   = 1'b1;
            if ((num_threads != 11'd0) && found) begin
              state_d   = ST_LOAD;
              base_d    = next_idx;
              cmask_d   = next_cmask;
              restart_d = 1'b1;
              issued_d  = 3'd1;
            end else begin
              state_d = ST_FIN;
              done_d  = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
        ST_SETTLE: begin
          if (settle_q == 2'(SETTLE_CYCLES - 1)) begin
            state_d = ST_RUN;
          end else begin
            settle_d = settle_q + 2'd1;
          end
        end
        ST_RUN: begin
          if (chunk_done) begin
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (found) begin
            state_d   = ST_LOAD;
            base_d    = next_idx;
            cmask_d   = next_cmask;
            restart_d = 1'b1;
            issued_d  = issued_q + 3'd1;
          end else begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      last_q    <= '0;
      base_q    <= '0;
      cmask_q   <= '0;
      uf_q      <= '0;
      issued_q  <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      last_q    <= last_d;
      base_q    <= base_d;
      cmask_q   <= cmask_d;
      uf_q      <= uf_d;
      issued_q  <= issued_d;
      settle_q  <= settle_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      restart_q <= restart_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign restart           = restart_q;
  assign chunk_active_mask = cmask_q;
  assign chunk_base_addr   = base_q;
  assign unrolling_factor  = uf_q;
  assign chunks_issued     = issued_q;

endmodule

// File: tb/tb_thread_chunk_sequencer.sv
// tb/tb_thread_chunk_sequencer.sv - scoreboard bench with randomized blocks for the chunk sequencer
module tb_thread_chunk_sequencer;

  localparam int K_RESTART = 0;
  localparam int K_ABORT   = 1;
  localparam int K_DONE    = 2;
  localparam int K_BAD     = 3;
  localparam int R_START   = 0;
  localparam int R_CD      = 1;
  localparam int R_ABORT   = 2;
  localparam int R_NONE    = 3;

  typedef struct {
    int           kind;
    int           rel;
    logic [1:0]   base;
    logic [255:0] cmask;
    logic [1:0]   uf;
    int           issued;
  } exp_t;

  logic          clk, rst, start, abort, chunk_done;
  logic [1023:0] active_mask;
  logic [10:0]   num_threads;
  logic [1:0]    unrolling_factor_in;
  logic          busy, done, restart;
  logic [255:0]  chunk_active_mask;
  logic [1:0]    chunk_base_addr, unrolling_factor;
  logic [2:0]    chunks_issued;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_edge, cd_edge, abort_edge, last_restart_obs;
  bit   held_mode;

  thread_chunk_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
    .active_mask         (active_mask),
    .num_threads         (num_threads),
    .unrolling_factor_in (unrolling_factor_in),
    .chunk_done          (chunk_done),
    .busy                (busy),
    .done                (done),
    .restart             (restart),
    .chunk_active_mask   (chunk_active_mask),
    .chunk_base_addr     (chunk_base_addr),
    .unrolling_factor    (unrolling_factor),
    .chunks_issued       (chunks_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Reference model: list the populated chunks of the in-range threads, in order.
  task automatic push_block(input logic [1023:0] mask, input logic [10:0] nt, input logic [1:0] uf,
                            input int abort_nth, input bit timed, output int n_issue);
    int            eff;
    int            cnt;
    bit            first;
    logic [1023:0] m;
    logic [255:0]  cm;
    exp_t          e;
    eff   = (nt > 11'd1024) ? 1024 : int'(nt);
    m     = '0;
    cnt   = 0;
    first = 1'b1;
    for (int i = 0; i < eff; i++) m[i] = mask[i];
    for (int c = 0; c < 4; c++) begin
      cm = m[c*256 +: 256];
      if (cm != '0 && (abort_nth < 0 || cnt <= abort_nth)) begin
        cnt++;
        e.kind   = K_RESTART;
        e.rel    = first ? R_START : (timed ? R_CD : R_NONE);
        e.base   = 2'(c);
        e.cmask  = cm;
        e.uf     = (uf == 2'd3) ? 2'd2 : uf;
        e.issued = cnt;
        sb_q.push_back(e);
        first = 1'b0;
      end
    end
    e.cmask  = '0;
    e.base   = '0;
    e.uf     = '0;
    e.issued = cnt;
    if (abort_nth >= 0) begin
      e.kind = K_ABORT;
      e.rel  = R_ABORT;
    end else begin
      e.kind = K_DONE;
      e.rel  = first ? R_START : (timed ? R_CD : R_NONE);
    end
    sb_q.push_back(e);
    n_issue = cnt;
  endtask

  task automatic issue_start(input logic [1023:0] mask, input logic [10:0] nt, input logic [1:0] uf);
    @(posedge clk);
    #1;
    active_mask         = mask;
    num_threads         = nt;
    unrolling_factor_in = uf;
    start               = 1'b1;
    @(posedge clk);
    #1;
    start_edge          = cyc;
    start               = 1'b0;
    active_mask         = {32{$urandom}};
    num_threads         = 11'($urandom);
    unrolling_factor_in = 2'($urandom);
  endtask

  task automatic wait_evt(input bit want_done, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      seen = want_done ? done : restart;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no pulse expected pulse within 64 cycles", nm);
    end
  endtask

  task automatic run_block(input logic [1023:0] mask, input logic [10:0] nt, input logic [1:0] uf,
                           input int abort_nth, input int dmin, input int dmax);
    int n;
    push_block(mask, nt, uf, abort_nth, 1'b1, n);
    issue_start(mask, nt, uf);
    for (int k = 0; k < n; k++) begin
      wait_evt(1'b0, "restart_timeout");
      if (k == abort_nth) begin
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort_edge = cyc;
        abort = 1'b0;
        wait_evt(1'b0, "abort_restart_timeout");
        break;
      end
      repeat ($urandom_range(dmin, dmax)) @(posedge clk);
      #1 chunk_done = 1'b1;
      @(posedge clk);
      #1 cd_edge = cyc;
      chunk_done = 1'b0;
    end
    if (abort_nth < 0) wait_evt(1'b1, "done_timeout");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("queue_drained", sb_q.size(), 0);
  endtask

  function automatic logic [1023:0] gen_mask();
    logic [1023:0] m;
    logic [255:0]  cm;
    int            p;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      p  = $urandom_range(0, 3);
      cm = '0;
      case (p)
        1: cm[$urandom_range(0, 255)] = 1'b1;
        2: for (int w = 0; w < 8; w++) cm[w*32 +: 32] = $urandom;
        3: cm = '1;
        default: cm = '0;
      endcase
      m[c*256 +: 256] = cm;
    end
    return m;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_restart"}, restart, 0);
    check({tag, "_chunk_mask"}, chunk_active_mask, 0);
    check({tag, "_base"}, chunk_base_addr, 0);
    check({tag, "_uf"}, unrolling_factor, 0);
    check({tag, "_issued"}, chunks_issued, 0);
  endtask

  // Monitor: every restart/done pulse is matched against the head of the scoreboard.
  exp_t me;
  int   act_kind, obs;
  always @(negedge clk) begin
    if (!rst && (restart || done)) begin
      obs = cyc + 1;
      if (restart && done)  act_kind = K_BAD;
      else if (restart)     act_kind = busy ? K_RESTART : K_ABORT;
      else                  act_kind = busy ? K_DONE : K_BAD;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d expected no event", act_kind, obs);
      end else begin
        me = sb_q.pop_front();
        check("event_kind", act_kind, me.kind);
        check("chunks_issued", chunks_issued, me.issued);
        if (me.kind == K_RESTART) begin
          check("chunk_base_addr", chunk_base_addr, me.base);
          check("chunk_active_mask", chunk_active_mask, me.cmask);
          check("unrolling_factor", unrolling_factor, me.uf);
          if (held_mode && me.rel != R_START)
            check("chunk_spacing_ge4", (obs - last_restart_obs) >= 4, 1);
        end
        case (me.rel)
          R_START: check("latency_from_start", obs, start_edge + 1);
          R_CD:    check("latency_from_chunk_done", obs, cd_edge + 2);
          R_ABORT: check("latency_from_abort", obs, abort_edge + 1);
          default: ;
        endcase
      end
      if (restart) last_restart_obs = obs;
    end
  end

  logic [1023:0] full_m, m600, zero_m;
  int            nt_tab[12] = '{0, 1, 255, 256, 257, 511, 512, 513, 768, 1023, 1024, 1500};
  int            n_tmp;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; chunk_done = 1'b0;
    active_mask = '0; num_threads = '0; unrolling_factor_in = '0;
    held_mode = 1'b0; last_restart_obs = 0;
    start_edge = 0; cd_edge = 0; abort_edge = 0;
    full_m = '1; zero_m = '0; m600 = '0; m600[600] = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    run_block(full_m, 11'd1024, 2'd0, -1, 3, 3);
    run_block(m600,   11'd1024, 2'd1, -1, 3, 5);
    run_block(full_m, 11'd300,  2'd2, -1, 3, 6);
    run_block(zero_m, 11'd1024, 2'd0, -1, 3, 3);
    run_block(full_m, 11'd0,    2'd3, -1, 3, 3);

    run_block(full_m, 11'd1024, 2'd1, 1, 3, 5);
    check("issued_hold_after_abort", chunks_issued, 2);
    run_block(full_m, 11'd1024, 2'd3, -1, 3, 4);

    // chunk_done stuck high, plus a start during busy that must be ignored.
    held_mode = 1'b1;
    chunk_done = 1'b1;
    push_block(full_m, 11'd1024, 2'd1, -1, 1'b0, n_tmp);
    issue_start(full_m, 11'd1024, 2'd1);
    wait_evt(1'b0, "held_restart_timeout");
    @(posedge clk);
    #1 start = 1'b1; active_mask = '0; num_threads = '0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_evt(1'b1, "held_done_timeout");
    chunk_done = 1'b0;
    repeat (3) @(negedge clk);
    held_mode = 1'b0;
    check("held_queue_drained", sb_q.size(), 0);

    // Reset in the middle of a chunk's RUN phase.
    push_block(full_m, 11'd1024, 2'd2, 0, 1'b1, n_tmp);
    void'(sb_q.pop_back());
    issue_start(full_m, 11'd1024, 2'd2);
    wait_evt(1'b0, "rst_restart_timeout");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("midrun_rst");
    check("rst_queue_drained", sb_q.size(), 0);

    for (int i = 0; i < 12; i++)
      run_block(gen_mask(), 11'(nt_tab[i]), 2'($urandom), -1, 3, 6);
    for (int i = 0; i < 16; i++)
      run_block(gen_mask(), 11'($urandom_range(0, 1100)), 2'($urandom), -1, 3, 6);

    check("final_queue_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thread_chunk_sequencer.md
Name: thread_chunk_sequencer

Overview:
- Controller that walks a 1024-bit per-block active mask through the next-thread logic one 256-bit chunk at a time.
- Latches the mask, thread count and unrolling factor on `start`.
- Drives chunk mask, chunk base address, unrolling factor and restart into the next-thread logic.
- Waits for that logic's `chunk_done`, skips all-zero chunks, and reports block completion to the dispatcher.

Parameters:
- MASK_W, 1024, total active-mask width (max threads per block)
- CHUNK_W, 256, chunk width presented per pass
- NUM_CHUNKS, 4, MASK_W/CHUNK_W; chunk index width is 2
- SETTLE_CYCLES, 2, cycles after restart during which `chunk_done` is ignored

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a block; honoured only in IDLE
- abort  in  1  cancel current block
- active_mask  in  1024  per-thread active mask for the block
- num_threads  in  11  thread count; valid range 1..1024
- unrolling_factor_in  in  2  0=1, 1=2, 2=4
- chunk_done  in  1  chunk fully drained, from next-thread logic
- busy  out  1  block in progress
- done  out  1  one-cycle pulse, block complete
- restart  out  1  one-cycle pulse that reloads the lanes
- chunk_active_mask  out  256  current chunk mask
- chunk_base_addr  out  2  current chunk index
- unrolling_factor  out  2  latched unrolling factor
- chunks_issued  out  3  nonzero chunks issued this block

Behaviour:
- Reset and output timing
  - All outputs are registered.
  - Reset value of every output is 0; state returns to IDLE.
- States: IDLE, LOAD, SETTLE, RUN, SCAN, FIN.
- IDLE
  - On `start`, latch the inputs:
    - `active_mask` with bits at index >= `num_threads` cleared.
    - last_chunk = (min(`num_threads`,1024)-1)>>8.
    - `unrolling_factor_in`; value 3 is stored as 2.
  - `num_threads`=0 → go to FIN.
  - Otherwise select the lowest nonzero chunk index <= last_chunk:
    - If one exists → LOAD.
    - If none → FIN.
  - `busy`=1 from the cycle after `start`.
- LOAD
  - Drive `chunk_active_mask`/`chunk_base_addr` for the selected chunk.
  - `restart`=1 for exactly this cycle.
  - `chunks_issued`+1.
  - Next state: SETTLE.
  - Chunk outputs stay stable from LOAD through RUN.
- SETTLE: count SETTLE_CYCLES cycles with `chunk_done` ignored, then → RUN.
- RUN: wait for `chunk_done`=1 sampled high, then → SCAN. There is no timeout.
- SCAN
  - Find the lowest nonzero chunk index greater than current and <= last_chunk.
  - Found → LOAD; none → FIN.
- FIN
  - `done`=1 for one cycle.
  - `busy` falls the next cycle.
  - Next state: IDLE.
- Latency
  - `start` sampled at edge t → `restart` high in cycle t+1.
  - `chunk_done` sampled at edge k → `restart` for the next chunk high in cycle k+2.
  - Last chunk → `done` high in cycle k+2.
- `start` while `busy`: ignored, no effect.
- `abort` in any non-IDLE state:
  - Takes priority over every other transition.
  - Next cycle: `restart`=1 for one cycle, state IDLE, `busy`=0, no `done`.
  - `chunks_issued` holds its value until the next `start`.
- `abort` in IDLE: ignored.
- `abort` and `start` in the same cycle in IDLE: `start` wins.
- `rst` mid-block: immediate return to IDLE next cycle; all outputs 0, including `restart`.
- Masks whose only set bits lie above `num_threads` are treated as empty.

Decomposition:
- Shared package dispatcher_pkg holds:
  - constants MASK_W, CHUNK_W, NUM_CHUNKS
  - typedef chunk_idx_t (2b)
  - enum seq_state_t
  - unrolling-factor encoding constants UF_1/UF_2/UF_4
- One sub-module: chunk_nonzero_finder.
  - Purely combinational.
  - Inputs: the per-chunk OR-reduction, the current index, a "first" flag, and last_chunk.
  - Outputs: next index and found.
- The FSM, counters and output registers live in the top.

Test Plan:
- Full mask, `num_threads`=1024, uf=0, `chunk_done` returned 3 cycles after each `restart`:
  - 4 `restart` pulses with base 0,1,2,3; `chunks_issued`=4; single `done`.
- Mask nonzero only in chunk 2 (bit 600), `num_threads`=1024:
  - one `restart` with base=2 and `chunk_active_mask` bit 88 set.
  - `done` follows 2 cycles after `chunk_done`.
- `num_threads`=300, mask all ones:
  - chunks 0 and 1 issued; chunk 1 mask = bits 0..43 only.
  - chunks 2..3 never issued.
- All-zero mask, and separately `num_threads`=0:
  - no `restart`; `done` pulses within 2 cycles of `start`; `chunks_issued`=0.
- `abort` in RUN of chunk 1:
  - one `restart` pulse, `busy`→0, no `done`.
  - A following `start` runs the block cleanly from chunk 0.
- `chunk_done` held high continuously:
  - chunks advance no faster than LOAD+SETTLE+RUN (4 cycles/chunk).
  - `start` during `busy` is ignored; `rst` mid-RUN clears all outputs next cycle.
